array_seq_ctrl: RTL



---
 rtl/array_seq_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/array_seq_ctrl.sv
// Sequencing controller for a weight-stationary systolic array: weight load through the
// array's pass-through mode, then skewed per-row feed and per-column capture enables.
module array_seq_ctrl #(
   parameter int ROW_NUMBER    = 256,
   parameter int COLUMN_NUMBER = 256,
   parameter int MAX_VEC       = 1024,
   parameter int DRAIN_OFFSET  = ROW_NUMBER
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic                            load_weights,
   input  logic [$clog2(MAX_VEC+1)-1:0]    num_vec,
   output logic                            busy,
   output logic                            done,
   output logic                            through,
   output logic                            w_rd_en,
   output logic [$clog2(ROW_NUMBER)-1:0]   w_rd_addr,
   output logic [ROW_NUMBER-1:0]           left_en,
   output logic [COLUMN_NUMBER-1:0]        down_en
);

   localparam int NVW   = $clog2(MAX_VEC+1);
   localparam int AW    = $clog2(ROW_NUMBER);
   localparam int TSPAN = DRAIN_OFFSET + COLUMN_NUMBER + MAX_VEC;
   localparam int RSPAN = ROW_NUMBER + MAX_VEC;
   // Counter is sized so that every window bound (r+NV, DRAIN_OFFSET+c+NV) fits unwrapped.
   localparam int CMAX  = (TSPAN > RSPAN) ? TSPAN : RSPAN;
   localparam int CW    = $clog2(CMAX+1);

   typedef logic [CW-1:0] cnt_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD_W  = 2'd1,
      COMPUTE = 2'd2,
      FINISH  = 2'd3
   } state_t;

   state_t               state, state_nx;
   cnt_t                 cnt, cnt_nx;
   logic [NVW-1:0]       nv, nv_nx;
   cnt_t                 t_end;
   logic [ROW_NUMBER-1:0]    left_nx;
   logic [COLUMN_NUMBER-1:0] down_nx;
   logic [AW-1:0]        addr_nx;

   assign t_end = cnt_t'(DRAIN_OFFSET + COLUMN_NUMBER - 2) + cnt_t'(nv);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      nv_nx    = nv;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (start) begin
               nv_nx = (num_vec > NVW'(MAX_VEC)) ? NVW'(MAX_VEC) : num_vec;
               if (load_weights)
                  state_nx = LOAD_W;
               else if (nv_nx != '0)
                  state_nx = COMPUTE;
               else
                  state_nx = FINISH;
            end
         end
         LOAD_W: begin
            if (cnt == cnt_t'(ROW_NUMBER - 1)) begin
               cnt_nx   = '0;
               state_nx = (nv != '0) ? COMPUTE : FINISH;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         COMPUTE: begin
            if (cnt == t_end) begin
               cnt_nx   = '0;
               state_nx = FINISH;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         FINISH: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end
         default: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state/count so the registered enables line up with t.
   always_comb begin
      left_nx = '0;
      down_nx = '0;
      addr_nx = '0;
      if (state_nx == COMPUTE) begin
         for (int r = 0; r < ROW_NUMBER; r++)
            left_nx[r] = (cnt_t'(r) <= cnt_nx) && (cnt_nx < cnt_t'(r) + cnt_t'(nv_nx));
         for (int c = 0; c < COLUMN_NUMBER; c++)
            down_nx[c] = (cnt_t'(DRAIN_OFFSET + c) <= cnt_nx) &&
                         (cnt_nx < cnt_t'(DRAIN_OFFSET + c) + cnt_t'(nv_nx));
      end
      if (state_nx == LOAD_W)
         addr_nx = AW'(ROW_NUMBER - 1) - cnt_nx[AW-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         nv        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         through   <= 1'b0;
         w_rd_en   <= 1'b0;
         w_rd_addr <= '0;
         left_en   <= '0;
         down_en   <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         nv        <= nv_nx;
         busy      <= (state_nx != IDLE);
         done      <= (state_nx == FINISH);
         through   <= (state_nx == LOAD_W);
         w_rd_en   <= (state_nx == LOAD_W);
         w_rd_addr <= addr_nx;
         left_en   <= left_nx;
         down_en   <= down_nx;
      end
   end

endmodule
